// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one single-port memory; grants are combinational.
// Read data returns one cycle after grant; data wins unless fetch has been starved MAX_D_BURST grants.
module mem_arbiter #(
  parameter int WORD_LEN    = 32,
  parameter int MAX_D_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [WORD_LEN-1:0] i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [WORD_LEN-1:0] i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [WORD_LEN-1:0] d_addr,
  input  logic [WORD_LEN-1:0] d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [WORD_LEN-1:0] d_rdata,
  output logic [WORD_LEN-1:0] m_addr,
  output logic                m_wen,
  output logic [WORD_LEN-1:0] m_wdata,
  input  logic [WORD_LEN-1:0] m_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RESP_I = 2'd1;
  localparam logic [1:0] RESP_D = 2'd2;

  localparam logic [3:0] CNT_MAX = 4'(MAX_D_BURST);

  logic [1:0] state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       i_win;

  // Grants are held off during reset so nothing is issued until the first post-release edge.
  always_comb begin
    i_win = i_req && (!d_req || (cnt == CNT_MAX));
    i_gnt = !rst && i_win;
    d_gnt = !rst && d_req && !i_win;
  end

  always_comb begin
    m_addr  = '0;
    m_wen   = 1'b0;
    m_wdata = '0;
    if (i_gnt) begin
      m_addr = i_addr;
    end else if (d_gnt) begin
      m_addr  = d_addr;
      m_wen   = d_we;
      m_wdata = d_wdata;
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    if (i_gnt || !i_req) begin
      cnt_nxt = '0;
    end else if (d_gnt && (cnt != CNT_MAX)) begin
      cnt_nxt = cnt + 4'd1;
    end
  end

  // Stores complete at grant, so only loads and fetches owe a response.
  always_comb begin
    state_nxt = IDLE;
    if (i_gnt) begin
      state_nxt = RESP_I;
    end else if (d_gnt && !d_we) begin
      state_nxt = RESP_D;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    i_rvalid = (state == RESP_I);
    d_rvalid = (state == RESP_D);
    i_rdata  = i_rvalid ? m_rdata : '0;
    d_rdata  = d_rvalid ? m_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed stimulus pushes expected grants/responses into queues; a negedge monitor pops and compares.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_wen;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [31:0] m_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.WORD_LEN(32), .MAX_D_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_wen(m_wen), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // Memory: unwritten words read as {addr[15:0], ~addr[15:0]}; one-cycle registered read.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_v;
  always @(posedge clk) begin
    rd_v = mem.exists(m_addr) ? mem[m_addr] : {m_addr[15:0], ~m_addr[15:0]};
    if (m_wen) mem[m_addr] = m_wdata;
    m_rdata <= rd_v;
  end

  typedef struct {
    bit          ig;
    bit          dg;
    logic [31:0] addr;
    bit          wen;
    logic [31:0] wdata;
  } grec_t;

  grec_t       gq[$];
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  int          checks = 0;
  int          passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    grec_t g;
    if (gq.size() > 0) begin
      g = gq.pop_front();
      chk("i_gnt", {31'b0, i_gnt}, {31'b0, g.ig});
      chk("d_gnt", {31'b0, d_gnt}, {31'b0, g.dg});
      chk("m_addr", m_addr, g.addr);
      chk("m_wen", {31'b0, m_wen}, {31'b0, g.wen});
      if (!g.ig) chk("m_wdata", m_wdata, g.wdata);
    end
    if (i_rvalid) begin
      if (iq.size() == 0) chk("i_rvalid_unexpected", {31'b0, i_rvalid}, 32'd0);
      else chk("i_rdata", i_rdata, iq.pop_front());
    end else begin
      chk("i_rdata_idle", i_rdata, 32'd0);
    end
    if (d_rvalid) begin
      if (dq.size() == 0) chk("d_rvalid_unexpected", {31'b0, d_rvalid}, 32'd0);
      else chk("d_rdata", d_rdata, dq.pop_front());
    end else begin
      chk("d_rdata_idle", d_rdata, 32'd0);
    end
  end

  // eg = expected {i_gnt, d_gnt}; erd = expected read data if the grant produces a response.
  task automatic cyc(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                     input logic [31:0] da, input logic [31:0] dwd,
                     input logic [1:0] eg, input logic [31:0] erd, input bit resp = 1'b1);
    grec_t g;
    @(posedge clk);
    #1;
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
    g.ig    = eg[1];
    g.dg    = eg[0];
    g.addr  = eg[1] ? ia : (eg[0] ? da : 32'd0);
    g.wen   = eg[0] && dw;
    g.wdata = eg[0] ? dwd : 32'd0;
    gq.push_back(g);
    if (resp) begin
      if (eg == 2'b10) iq.push_back(erd);
      else if (eg == 2'b01 && !dw) dq.push_back(erd);
    end
  endtask

  task automatic idle();
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Requests during reset must not be granted.
    cyc(1'b1, 32'h10, 1'b1, 1'b0, 32'h200, 32'd0, 2'b00, 32'd0);
    @(negedge clk); #2;
    i_req = 1'b0; d_req = 1'b0; rst = 1'b0;

    // Fetch alone, granted on the first edge after release.
    cyc(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 2'b10, 32'h0010FFEF);
    idle();

    // Simultaneous: data wins, then the held fetch.
    cyc(1'b1, 32'h10, 1'b1, 1'b0, 32'h200, 32'd0, 2'b01, 32'h0200FDFF);
    cyc(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 2'b10, 32'h0010FFEF);

    // Store then load back.
    cyc(1'b0, 32'd0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 2'b01, 32'd0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'h40, 32'd0, 2'b01, 32'hDEADBEEF);
    idle();

    // Starvation limit: four data grants, one fetch, repeat.
    cyc(1'b1, 32'h100, 1'b1, 1'b0, 32'h300, 32'd0, 2'b01, 32'h0300FCFF);
    cyc(1'b1, 32'h100, 1'b1, 1'b0, 32'h304, 32'd0, 2'b01, 32'h0304FCFB);
    cyc(1'b1, 32'h100, 1'b1, 1'b0, 32'h308, 32'd0, 2'b01, 32'h0308FCF7);
    cyc(1'b1, 32'h100, 1'b1, 1'b0, 32'h30C, 32'd0, 2'b01, 32'h030CFCF3);
    cyc(1'b1, 32'h100, 1'b1, 1'b0, 32'h310, 32'd0, 2'b10, 32'h0100FEFF);
    cyc(1'b1, 32'h104, 1'b1, 1'b0, 32'h310, 32'd0, 2'b01, 32'h0310FCEF);
    cyc(1'b1, 32'h104, 1'b1, 1'b0, 32'h314, 32'd0, 2'b01, 32'h0314FCEB);
    cyc(1'b1, 32'h104, 1'b1, 1'b0, 32'h318, 32'd0, 2'b01, 32'h0318FCE7);
    cyc(1'b1, 32'h104, 1'b1, 1'b0, 32'h31C, 32'd0, 2'b01, 32'h031CFCE3);
    cyc(1'b1, 32'h104, 1'b1, 1'b0, 32'h320, 32'd0, 2'b10, 32'h0104FEFB);
    cyc(1'b0, 32'd0,   1'b1, 1'b0, 32'h320, 32'd0, 2'b01, 32'h0320FCDF);
    idle();

    // Alternating fetch/load, responses routed back-to-back.
    cyc(1'b1, 32'h20, 1'b0, 1'b0, 32'd0,  32'd0, 2'b10, 32'h0020FFDF);
    cyc(1'b0, 32'd0,  1'b1, 1'b0, 32'h44, 32'd0, 2'b01, 32'h0044FFBB);
    cyc(1'b1, 32'h24, 1'b0, 1'b0, 32'd0,  32'd0, 2'b10, 32'h0024FFDB);
    cyc(1'b0, 32'd0,  1'b1, 1'b0, 32'h48, 32'd0, 2'b01, 32'h0048FFB7);
    idle();

    // Load granted, then reset before the response edge: response must vanish.
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'h200, 32'd0, 2'b01, 32'd0, 1'b0);
    @(negedge clk); #2;
    rst = 1'b1;
    cyc(1'b1, 32'h10, 1'b1, 1'b0, 32'h200, 32'd0, 2'b00, 32'd0);
    @(negedge clk); #2;
    i_req = 1'b0; d_req = 1'b0; rst = 1'b0;
    idle();
    cyc(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 2'b10, 32'h0010FFEF);
    idle();
    idle();

    @(negedge clk); #2;
    chk("iq_drained", iq.size(), 32'd0);
    chk("dq_drained", dq.size(), 32'd0);
    chk("gq_drained", gq.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
